// File: rtl/frontend_pkg.sv
// Shared frontend types: the entry format carried from fetch to issue and
// the default depth of the issue-side skid buffer.
package frontend_pkg;

   localparam int ISSUE_BUF_DEPTH = 4;
   localparam int FE_XLEN         = 32;
   localparam int FE_ILEN         = 32;

   // One fetched instruction together with its branch prediction.
   typedef struct packed {
      logic [FE_XLEN-1:0] pc;
      logic [FE_ILEN-1:0] instr;
      logic               pred_taken;
      logic [FE_XLEN-1:0] pred_target;
   } fetch_entry_t;

endpackage

// File: rtl/issue_stage_tx.sv
// Transmit side of the frontend-to-backend issue handshake. Fetched entries
// go into a small circular buffer. The head entry is offered to the issue
// queue with valid/ready. Both handshake flags come only from the occupancy
// count, so there is no combinational path from issue_ready_i to
// fetch_ready_o. A full buffer therefore stays closed for one cycle after a
// dequeue.
// XLEN and ILEN must match the field widths of frontend_pkg::fetch_entry_t.
module issue_stage_tx
   import frontend_pkg::*;
#(
   parameter int DEPTH = ISSUE_BUF_DEPTH,
   parameter int XLEN  = FE_XLEN,
   parameter int ILEN  = FE_ILEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            fetch_valid_i,
   output logic            fetch_ready_o,
   input  logic [XLEN-1:0] fetch_pc_i,
   input  logic [ILEN-1:0] fetch_instr_i,
   input  logic            fetch_pred_taken_i,
   input  logic [XLEN-1:0] fetch_pred_target_i,
   output logic            issue_valid_o,
   input  logic            issue_ready_i,
   output logic [XLEN-1:0] issue_pc_o,
   output logic [ILEN-1:0] issue_instr_o,
   output logic            issue_pred_taken_o,
   output logic [XLEN-1:0] issue_pred_target_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem [DEPTH];
   fetch_entry_t     wr_entry;
   fetch_entry_t     head_entry;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             enq;
   logic             deq;

   // The flags depend only on the registered count. DEPTH is a power of two,
   // so the pointers wrap at DEPTH simply by overflowing.
   assign fetch_ready_o = (count != CNT_W'(DEPTH));
   assign issue_valid_o = (count != '0);
   assign enq           = fetch_valid_i && fetch_ready_o;
   assign deq           = issue_valid_o && issue_ready_i;

   assign wr_entry.pc          = fetch_pc_i;
   assign wr_entry.instr       = fetch_instr_i;
   assign wr_entry.pred_taken  = fetch_pred_taken_i;
   assign wr_entry.pred_target = fetch_pred_target_i;

   // The issue data comes straight from the head slot. It stays stable while
   // the head waits, because a slot is only rewritten after it is dequeued.
   assign head_entry          = mem[head];
   assign issue_pc_o          = head_entry.pc;
   assign issue_instr_o       = head_entry.instr;
   assign issue_pred_taken_o  = head_entry.pred_taken;
   assign issue_pred_target_o = head_entry.pred_target;

   // Pointer and occupancy bookkeeping. Reset beats flush, and flush beats
   // any handshake in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            tail <= tail + PTR_W'(1);
         end
         if (deq) begin
            head <= head + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write. There is no data reset; a fetch entry offered during
   // reset or flush is dropped.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && enq) begin
         mem[tail] <= wr_entry;
      end
   end

endmodule

// File: tb/tb_issue_stage_tx.sv
// Directed bench for issue_stage_tx. Each scenario task drives the fetch and
// issue sides and compares the outputs with hand-derived values.
module tb_issue_stage_tx;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        fetch_valid_i;
   logic        fetch_ready_o;
   logic [31:0] fetch_pc_i;
   logic [31:0] fetch_instr_i;
   logic        fetch_pred_taken_i;
   logic [31:0] fetch_pred_target_i;
   logic        issue_valid_o;
   logic        issue_ready_i;
   logic [31:0] issue_pc_o;
   logic [31:0] issue_instr_o;
   logic        issue_pred_taken_o;
   logic [31:0] issue_pred_target_o;

   int pass_count  = 0;
   int check_count = 0;

   issue_stage_tx dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .flush_i             (flush_i),
      .fetch_valid_i       (fetch_valid_i),
      .fetch_ready_o       (fetch_ready_o),
      .fetch_pc_i          (fetch_pc_i),
      .fetch_instr_i       (fetch_instr_i),
      .fetch_pred_taken_i  (fetch_pred_taken_i),
      .fetch_pred_target_i (fetch_pred_target_i),
      .issue_valid_o       (issue_valid_o),
      .issue_ready_i       (issue_ready_i),
      .issue_pc_o          (issue_pc_o),
      .issue_instr_o       (issue_instr_o),
      .issue_pred_taken_o  (issue_pred_taken_o),
      .issue_pred_target_o (issue_pred_target_o)
   );

   always #5 clk_i = ~clk_i;

   // The payload is derived from the PC, so one PC fixes every field the
   // bench expects to see.
   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hDEAD_0000;
   endfunction

   function automatic logic [31:0] target_of(input logic [31:0] pc);
      return pc + 32'h40;
   endfunction

   function automatic logic [96:0] payload_of(input logic [31:0] pc);
      return {pc, instr_of(pc), pc[2], target_of(pc)};
   endfunction

   // Advance one cycle and settle 1 ns past the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_fetch(input logic valid, input logic [31:0] pc);
      fetch_valid_i       = valid;
      fetch_pc_i          = pc;
      fetch_instr_i       = instr_of(pc);
      fetch_pred_taken_i  = pc[2];
      fetch_pred_target_i = target_of(pc);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      check_count++;
      if (issue_valid_o !== 1'b0)
         $display("[TB] FAIL reset_valid: got %b expected 0", issue_valid_o);
      else pass_count++;
      check_count++;
      if (fetch_ready_o !== 1'b1)
         $display("[TB] FAIL reset_ready: got %b expected 1", fetch_ready_o);
      else pass_count++;
   endtask

   task automatic test_stream();
      logic [31:0] pc;
      issue_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pc = 32'h100 + 32'(4 * i);
         drive_fetch(1'b1, pc);
         tick();
         check_count++;
         if ({issue_valid_o, issue_pc_o} !== {1'b1, pc})
            $display("[TB] FAIL stream_pc[%0d]: got %b/%h expected 1/%h", i, issue_valid_o, issue_pc_o, pc);
         else pass_count++;
         check_count++;
         if (fetch_ready_o !== 1'b1)
            $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, fetch_ready_o);
         else pass_count++;
      end
      check_count++;
      if ({issue_instr_o, issue_pred_taken_o, issue_pred_target_o} !== {instr_of(32'h10C), 1'b1, target_of(32'h10C)})
         $display("[TB] FAIL stream_data: got %h/%b/%h expected %h/1/%h", issue_instr_o, issue_pred_taken_o, issue_pred_target_o, instr_of(32'h10C), target_of(32'h10C));
      else pass_count++;
      drive_fetch(1'b0, 32'h0);
      tick();
      check_count++;
      if (issue_valid_o !== 1'b0)
         $display("[TB] FAIL stream_drain: got %b expected 0", issue_valid_o);
      else pass_count++;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      issue_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_fetch(1'b1, 32'h100 + 32'(4 * i));
         check_count++;
         if (fetch_ready_o !== (i < 4))
            $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", i, fetch_ready_o, (i < 4));
         else pass_count++;
         tick();
      end
      check_count++;
      if ({fetch_ready_o, issue_valid_o, issue_pc_o} !== {1'b0, 1'b1, 32'h100})
         $display("[TB] FAIL bp_full: got ready=%b valid=%b pc=%h expected ready=0 valid=1 pc=00000100", fetch_ready_o, issue_valid_o, issue_pc_o);
      else pass_count++;
      // Full buffer, with both the 5th entry and the issue side ready:
      // only the dequeue may happen.
      issue_ready_i = 1'b1;
      tick();
      issue_ready_i = 1'b0;
      check_count++;
      if ({fetch_ready_o, issue_pc_o} !== {1'b1, 32'h104})
         $display("[TB] FAIL bp_full_pop: got ready=%b pc=%h expected ready=1 pc=00000104", fetch_ready_o, issue_pc_o);
      else pass_count++;
      tick();
      drive_fetch(1'b0, 32'h0);
      check_count++;
      if (fetch_ready_o !== 1'b0)
         $display("[TB] FAIL bp_fifth_in: got %b expected 0", fetch_ready_o);
      else pass_count++;
      issue_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'h104 + 32'(4 * i);
         check_count++;
         if ({issue_valid_o, issue_pc_o} !== {1'b1, exp_pc})
            $display("[TB] FAIL bp_order[%0d]: got %b/%h expected 1/%h", i, issue_valid_o, issue_pc_o, exp_pc);
         else pass_count++;
         tick();
      end
      check_count++;
      if (issue_valid_o !== 1'b0)
         $display("[TB] FAIL bp_empty: got %b expected 0", issue_valid_o);
      else pass_count++;
   endtask

   task automatic test_flush();
      issue_ready_i = 1'b0;
      drive_fetch(1'b1, 32'h200);
      tick();
      drive_fetch(1'b1, 32'h204);
      tick();
      drive_fetch(1'b1, 32'h208);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      drive_fetch(1'b0, 32'h0);
      check_count++;
      if ({issue_valid_o, fetch_ready_o} !== 2'b01)
         $display("[TB] FAIL flush_clear: got valid=%b ready=%b expected valid=0 ready=1", issue_valid_o, fetch_ready_o);
      else pass_count++;
      tick();
      check_count++;
      if (issue_valid_o !== 1'b0)
         $display("[TB] FAIL flush_discard: got %b expected 0", issue_valid_o);
      else pass_count++;
      drive_fetch(1'b1, 32'h300);
      tick();
      drive_fetch(1'b0, 32'h0);
      check_count++;
      if ({issue_valid_o, issue_pc_o} !== {1'b1, 32'h300})
         $display("[TB] FAIL flush_next: got %b/%h expected 1/00000300", issue_valid_o, issue_pc_o);
      else pass_count++;
      issue_ready_i = 1'b1;
      tick();
      check_count++;
      if (issue_valid_o !== 1'b0)
         $display("[TB] FAIL flush_drain: got %b expected 0", issue_valid_o);
      else pass_count++;
   endtask

   task automatic test_hold();
      issue_ready_i = 1'b0;
      drive_fetch(1'b1, 32'h404);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive_fetch(i < 3, 32'h408 + 32'(4 * i));
         check_count++;
         if ({issue_valid_o, issue_pc_o, issue_instr_o, issue_pred_taken_o, issue_pred_target_o} !== {1'b1, payload_of(32'h404)})
            $display("[TB] FAIL hold[%0d]: got %b/%h/%h/%b/%h expected 1/%h", i, issue_valid_o, issue_pc_o, issue_instr_o, issue_pred_taken_o, issue_pred_target_o, payload_of(32'h404));
         else pass_count++;
         tick();
      end
      drive_fetch(1'b0, 32'h0);
      issue_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check_count++;
      if (issue_valid_o !== 1'b0)
         $display("[TB] FAIL hold_drain: got %b expected 0", issue_valid_o);
      else pass_count++;
   endtask

   task automatic test_random_wrap();
      logic [31:0] sb[$];
      logic [31:0] next_pc;
      logic        v;
      logic        r;
      logic        exp_enq;
      logic        exp_deq;
      next_pc = 32'h500;
      for (int c = 0; c < 20; c++) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         drive_fetch(v, next_pc);
         issue_ready_i = r;
         check_count++;
         if ({fetch_ready_o, issue_valid_o} !== {sb.size() != 4, sb.size() != 0})
            $display("[TB] FAIL rand_flags[%0d]: got ready=%b valid=%b expected ready=%b valid=%b", c, fetch_ready_o, issue_valid_o, sb.size() != 4, sb.size() != 0);
         else pass_count++;
         if (sb.size() != 0) begin
            check_count++;
            if ({issue_pc_o, issue_instr_o} !== {sb[0], instr_of(sb[0])})
               $display("[TB] FAIL rand_order[%0d]: got %h/%h expected %h/%h", c, issue_pc_o, issue_instr_o, sb[0], instr_of(sb[0]));
            else pass_count++;
         end
         exp_enq = v && (sb.size() != 4);
         exp_deq = r && (sb.size() != 0);
         if (exp_deq) void'(sb.pop_front());
         if (exp_enq) begin
            sb.push_back(next_pc);
            next_pc = next_pc + 32'h4;
         end
         tick();
      end
      drive_fetch(1'b1, 32'h600);
      issue_ready_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      drive_fetch(1'b0, 32'h0);
      check_count++;
      if ({issue_valid_o, fetch_ready_o} !== 2'b01)
         $display("[TB] FAIL rand_reset: got valid=%b ready=%b expected valid=0 ready=1", issue_valid_o, fetch_ready_o);
      else pass_count++;
      tick();
      check_count++;
      if (issue_valid_o !== 1'b0)
         $display("[TB] FAIL rand_reset_discard: got %b expected 0", issue_valid_o);
      else pass_count++;
   endtask

   initial begin
      rst_i         = 1'b1;
      flush_i       = 1'b0;
      issue_ready_i = 1'b0;
      drive_fetch(1'b0, 32'h0);
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_hold();
      test_random_wrap();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
